multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand/result width; legal values are even and >= 4.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width; it is derived and never overridden.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present on aluop/a/b.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 aluop  input  lc3b_aluop  operation select.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result present on f/cc/err.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 f  output  WIDTH  result.
REQ-012 cc  output  3  {n,z,p} of f as a signed value; exactly one bit is set.
REQ-013 err  output  1  divide-by-zero or undefined aluop.

Function
REQ-014 Request accepted on an edge where in_valid && in_ready; aluop/a/b captured into internal registers at that edge.
REQ-015 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Single-cycle ops: IDLE->DONE at accept; out_valid 1 cycle after accept.
- add: a+b mod 2^WIDTH
- and: a&b
- not: ~a
- pass: a
- sll: a<<b[SHW-1:0]
- srl: logical a>>b[SHW-1:0]
- sra: arithmetic a>>>b[SHW-1:0]
- bitcopy: low WIDTH/2 bits of a replicated twice
REQ-017 mul: unsigned shift-add; low WIDTH bits of a*b; IDLE->BUSY; exactly WIDTH BUSY cycles, then DONE; out_valid WIDTH+1 cycles after accept.
REQ-018 div/rem: unsigned restoring division; div returns quotient, rem returns remainder; same timing as mul.
REQ-019 div/rem with b==0: no BUSY phase; DONE after 1 cycle with f=all ones (div) or f=a (rem), err=1.
REQ-020 Undefined aluop: DONE after 1 cycle with f=0, err=1.
REQ-021 err=0 for all other results; cc derived from final f in every case, including error results.
REQ-022 f/cc/err are registered and held stable while out_valid && !out_ready.
REQ-023 DONE->IDLE on the edge where out_ready=1; no new request is accepted on that same edge (in_ready is low in DONE).
REQ-024 in_valid while BUSY/DONE is ignored; no overlap, no queueing.
REQ-025 Operands changing after accept do not affect the in-flight result.

Reset
REQ-026 reset asserted -> state=IDLE, out_valid=0, f=0, cc=3'b010 (z), err=0, iteration counter=0, all within the assertion, without a clock edge.
REQ-027 reset mid-BUSY or mid-DONE discards the operation; no out_valid is produced for it after release.
REQ-028 First accept possible on the first rising edge after reset deasserts.

Structure
REQ-029 lc3b_types package SHALL extend lc3b_aluop with alu_mul, alu_div, alu_rem and SHALL define lc3b_nzp (3 bits); no local enum copies.
REQ-030 The iterative shift-add/shift-subtract engine SHALL be one sub-module, alu_iter_unit (start, op, a, b -> done, result), parametrised by WIDTH.
REQ-031 Single-cycle ops, FSM and output registers SHALL reside in multicycle_alu.

Verification (WIDTH=16 unless stated)
REQ-032 add 0x7FFF+0x0001 -> f=0x8000, cc=100, err=0, out_valid exactly 1 cycle after accept.
REQ-033 sra a=0x8000 b=0x0013 -> f=0xF000 (amount 3); bitcopy a=0x12AB -> f=0xABAB.
REQ-034 mul 0x0123*0x0010 -> f=0x1230, out_valid 17 cycles after accept, in_ready low for those cycles; WIDTH=8 mul 0x10*0x10 -> 0x00, cc=010.
REQ-035 div 100/7 -> f=14; rem 100/7 -> f=2; div 5/0 -> f=0xFFFF, err=1, latency 1.
REQ-036 hold out_ready=0 for 5 cycles after DONE -> f/cc/err unchanged and in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-037 reset asserted 4 cycles into a mul -> out_valid=0 immediately; no result emitted; next add accepted normally.

Source files
------------

// File: rtl/multicycle_alu_pkg.sv
// Shared types for the multicycle ALU: the LC-3b ALU opcode set (extended with
// the iterative operations), the condition-code type and the control FSM states.
package lc3b_types;

   typedef enum logic [3:0] {
      alu_add     = 4'd0,
      alu_and     = 4'd1,
      alu_not     = 4'd2,
      alu_pass    = 4'd3,
      alu_sll     = 4'd4,
      alu_srl     = 4'd5,
      alu_sra     = 4'd6,
      alu_bitcopy = 4'd7,
      alu_mul     = 4'd8,
      alu_div     = 4'd9,
      alu_rem     = 4'd10
   } lc3b_aluop;

   typedef logic [2:0] lc3b_nzp;

   localparam lc3b_nzp NZP_NEG  = 3'b100;
   localparam lc3b_nzp NZP_ZERO = 3'b010;
   localparam lc3b_nzp NZP_POS  = 3'b001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/multicycle_alu_iter.sv
// Iterative engine: unsigned shift-add multiply and restoring divide.
// One bit is processed per clock. The final (WIDTH-th) step is not registered
// here; it is presented combinationally on result while done is high, so the
// parent captures it on the same edge and sees exactly WIDTH busy cycles.
module alu_iter_unit
   import lc3b_types::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  lc3b_aluop        op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   logic             running;
   logic [SHW-1:0]   cnt;
   lc3b_aluop        op_q;
   // mul: multiplicand (shifts left); div/rem: dividend shifting into quotient
   logic [WIDTH-1:0] opnd_a;
   // mul: multiplier (shifts right); div/rem: divisor (constant)
   logic [WIDTH-1:0] opnd_b;
   // mul: partial product; div/rem: partial remainder
   logic [WIDTH-1:0] acc;

   logic [WIDTH-1:0] nxt_a;
   logic [WIDTH-1:0] nxt_b;
   logic [WIDTH-1:0] nxt_acc;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // One iteration step of the selected algorithm
   always_comb begin
      nxt_a   = opnd_a;
      nxt_b   = opnd_b;
      nxt_acc = acc;
      shifted = '0;
      diff    = '0;
      if (op_q == alu_mul) begin
         nxt_acc = acc + (opnd_b[0] ? opnd_a : '0);
         nxt_a   = opnd_a << 1;
         nxt_b   = opnd_b >> 1;
      end else begin
         // Bring the next dividend bit into the remainder and try a subtract;
         // a clear borrow bit means the divisor fit and the quotient bit is 1.
         shifted = {acc, opnd_a[WIDTH-1]};
         diff    = shifted - {1'b0, opnd_b};
         nxt_acc = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         nxt_a   = {opnd_a[WIDTH-2:0], ~diff[WIDTH]};
      end
   end

   assign done   = running && (cnt == LAST);
   assign result = (op_q == alu_div) ? nxt_a : nxt_acc;

   // Iteration control: counts completed steps, stops after the last one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
      end else if (running) begin
         if (cnt == LAST) begin
            running <= 1'b0;
            cnt     <= '0;
         end else begin
            cnt <= cnt + SHW'(1);
         end
      end
   end

   // Operand capture on start, then one algorithm step per cycle
   always_ff @(posedge clk) begin
      if (start) begin
         op_q   <= op;
         opnd_a <= a;
         opnd_b <= b;
         acc    <= '0;
      end else if (running) begin
         opnd_a <= nxt_a;
         opnd_b <= nxt_b;
         acc    <= nxt_acc;
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle LC-3b operations plus iterative mul/div/rem,
// wrapped in a valid/ready request/response handshake with one operation in
// flight at a time. Results and condition codes are registered and held until
// the consumer takes them.
module multicycle_alu
   import lc3b_types::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  lc3b_aluop        aluop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output lc3b_nzp          cc,
   output logic             err
);

   alu_state_t       state;
   logic [WIDTH-1:0] sc_f;
   logic             sc_err;
   logic             is_iter;
   logic             start;
   logic             iter_done;
   logic [WIDTH-1:0] iter_result;
   logic [SHW-1:0]   sh;

   // Condition code of a result interpreted as a signed value
   function automatic lc3b_nzp nzp_of(input logic [WIDTH-1:0] v);
      if (v[WIDTH-1])
         return NZP_NEG;
      else if (v == '0)
         return NZP_ZERO;
      else
         return NZP_POS;
   endfunction

   assign sh = b[SHW-1:0];

   // Single-cycle results, error cases and routing of iterative operations
   always_comb begin
      sc_f    = '0;
      sc_err  = 1'b0;
      is_iter = 1'b0;
      case (aluop)
         alu_add:     sc_f = a + b;
         alu_and:     sc_f = a & b;
         alu_not:     sc_f = ~a;
         alu_pass:    sc_f = a;
         alu_sll:     sc_f = a << sh;
         alu_srl:     sc_f = a >> sh;
         alu_sra:     sc_f = $signed(a) >>> sh;
         alu_bitcopy: sc_f = {a[WIDTH/2-1:0], a[WIDTH/2-1:0]};
         alu_mul:     is_iter = 1'b1;
         alu_div: begin
            // Divide by zero completes immediately with an all-ones quotient
            if (b == '0) begin
               sc_f   = '1;
               sc_err = 1'b1;
            end else begin
               is_iter = 1'b1;
            end
         end
         alu_rem: begin
            // Remainder by zero completes immediately returning the dividend
            if (b == '0) begin
               sc_f   = a;
               sc_err = 1'b1;
            end else begin
               is_iter = 1'b1;
            end
         end
         default: begin
            sc_f   = '0;
            sc_err = 1'b1;
         end
      endcase
   end

   assign start = (state == IDLE) && in_valid && is_iter;

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_iter (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (aluop),
      .a      (a),
      .b      (b),
      .done   (iter_done),
      .result (iter_result)
   );

   // Control FSM with registered handshake outputs and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         f         <= '0;
         cc        <= NZP_ZERO;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (is_iter) begin
                     state <= BUSY;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     f         <= sc_f;
                     cc        <= nzp_of(sc_f);
                     err       <= sc_err;
                  end
               end
            end
            BUSY: begin
               if (iter_done) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  f         <= iter_result;
                  cc        <= nzp_of(iter_result);
                  err       <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: vector table for every operation class,
// plus hand sequences for result hold, reset mid-operation and WIDTH=8 multiply.
module tb_multicycle_alu;
   import lc3b_types::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   lc3b_aluop   aluop;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] f;
   lc3b_nzp     cc;
   logic        err;

   logic        v8_in_valid;
   logic        v8_in_ready;
   lc3b_aluop   v8_aluop;
   logic [7:0]  v8_a, v8_b;
   logic        v8_out_valid;
   logic        v8_out_ready;
   logic [7:0]  v8_f;
   lc3b_nzp     v8_cc;
   logic        v8_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_alu #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .f(f), .cc(cc), .err(err)
   );

   multicycle_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
      .aluop(v8_aluop), .a(v8_a), .b(v8_b), .out_valid(v8_out_valid),
      .out_ready(v8_out_ready), .f(v8_f), .cc(v8_cc), .err(v8_err)
   );

   typedef struct {
      string       name;
      lc3b_aluop   op;
      logic [15:0] va;
      logic [15:0] vb;
      logic [15:0] ef;
      logic [2:0]  ecc;
      logic        eerr;
      int          elat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request, wait for the result (bounded), then release it.
   task automatic run16(input lc3b_aluop op, input logic [15:0] ia, input logic [15:0] ib,
                        output logic [15:0] rf, output logic [2:0] rcc, output logic rerr,
                        output int lat, output logic busy_ok, output logic rel_ok);
      @(negedge clk);
      in_valid = 1'b1; aluop = op; a = ia; b = ib;
      @(posedge clk); #1;
      // scramble operands after accept; the in-flight result must not change
      in_valid = 1'b0; a = ~ia; b = ~ib; aluop = alu_add;
      lat = 1; busy_ok = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (in_ready) busy_ok = 1'b0;
      rf = f; rcc = cc; rerr = err;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      rel_ok = in_ready && !out_valid;
   endtask

   vec_t vecs[$];

   initial begin
      logic [15:0] rf;
      logic [2:0]  rcc;
      logic        rerr, busy_ok, rel_ok;
      int          lat;
      logic [15:0] hf;
      logic [2:0]  hcc;
      logic        herr;
      logic        stray;

      vecs.push_back('{"add_ovf",  alu_add,     16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1'b0, 1});
      vecs.push_back('{"add_wrap", alu_add,     16'hFFFF, 16'h0001, 16'h0000, 3'b010, 1'b0, 1});
      vecs.push_back('{"and",      alu_and,     16'hF0F0, 16'h0FF0, 16'h00F0, 3'b001, 1'b0, 1});
      vecs.push_back('{"not",      alu_not,     16'h00FF, 16'h1234, 16'hFF00, 3'b100, 1'b0, 1});
      vecs.push_back('{"pass",     alu_pass,    16'h0000, 16'hFFFF, 16'h0000, 3'b010, 1'b0, 1});
      vecs.push_back('{"sll",      alu_sll,     16'h0001, 16'h0004, 16'h0010, 3'b001, 1'b0, 1});
      vecs.push_back('{"srl",      alu_srl,     16'h8000, 16'h0013, 16'h1000, 3'b001, 1'b0, 1});
      vecs.push_back('{"sra",      alu_sra,     16'h8000, 16'h0013, 16'hF000, 3'b100, 1'b0, 1});
      vecs.push_back('{"bitcopy",  alu_bitcopy, 16'h12AB, 16'h0000, 16'hABAB, 3'b100, 1'b0, 1});
      vecs.push_back('{"mul",      alu_mul,     16'h0123, 16'h0010, 16'h1230, 3'b001, 1'b0, 17});
      vecs.push_back('{"mul_max",  alu_mul,     16'hFFFF, 16'hFFFF, 16'h0001, 3'b001, 1'b0, 17});
      vecs.push_back('{"div",      alu_div,     16'd100,  16'd7,    16'd14,   3'b001, 1'b0, 17});
      vecs.push_back('{"rem",      alu_rem,     16'd100,  16'd7,    16'd2,    3'b001, 1'b0, 17});
      vecs.push_back('{"div_big",  alu_div,     16'hFFFF, 16'h0001, 16'hFFFF, 3'b100, 1'b0, 17});
      vecs.push_back('{"rem_big",  alu_rem,     16'hFFFF, 16'h0010, 16'h000F, 3'b001, 1'b0, 17});
      vecs.push_back('{"div_zero", alu_div,     16'd5,    16'd0,    16'hFFFF, 3'b100, 1'b1, 1});
      vecs.push_back('{"rem_zero", alu_rem,     16'd5,    16'd0,    16'h0005, 3'b001, 1'b1, 1});
      vecs.push_back('{"undef",    lc3b_aluop'(4'hC), 16'h1111, 16'h2222, 16'h0000, 3'b010, 1'b1, 1});

      reset = 1'b1; in_valid = 1'b0; aluop = alu_add; a = '0; b = '0; out_ready = 1'b0;
      v8_in_valid = 1'b0; v8_aluop = alu_add; v8_a = '0; v8_b = '0; v8_out_ready = 1'b0;
      #1;
      chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_f",         {16'd0, f},         32'h0);
      chk("reset_cc",        {29'd0, cc},        32'h2);
      chk("reset_err",       {31'd0, err},       32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run16(vecs[i].op, vecs[i].va, vecs[i].vb, rf, rcc, rerr, lat, busy_ok, rel_ok);
         chk({vecs[i].name, "_f"},       {16'd0, rf},        {16'd0, vecs[i].ef});
         chk({vecs[i].name, "_cc"},      {29'd0, rcc},       {29'd0, vecs[i].ecc});
         chk({vecs[i].name, "_err"},     {31'd0, rerr},      {31'd0, vecs[i].eerr});
         chk({vecs[i].name, "_latency"}, lat,                vecs[i].elat);
         chk({vecs[i].name, "_busy"},    {31'd0, busy_ok},   32'd1);
         chk({vecs[i].name, "_release"}, {31'd0, rel_ok},    32'd1);
      end

      // Result hold under back-pressure, with in_valid ignored while DONE
      @(negedge clk);
      in_valid = 1'b1; aluop = alu_mul; a = 16'd3; b = 16'd5;
      @(posedge clk); #1;
      a = 16'd1; b = 16'd1; aluop = alu_add;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hold_latency", lat, 17);
      hf = f; hcc = cc; herr = err;
      chk("hold_f0", {16'd0, hf}, 32'd15);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_f",     {16'd0, f},   {16'd0, hf});
         chk("hold_cc",    {29'd0, cc},  {29'd0, hcc});
         chk("hold_err",   {31'd0, err}, {31'd0, herr});
         chk("hold_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_release_ready", {31'd0, in_ready},  32'd1);
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;

      // Reset four cycles into a multiply discards it
      @(negedge clk);
      in_valid = 1'b1; aluop = alu_mul; a = 16'h0123; b = 16'h0010;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_mid_f",         {16'd0, f},         32'd0);
      chk("rst_mid_cc",        {29'd0, cc},        32'h2);
      @(negedge clk);
      reset = 1'b0;
      stray = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (out_valid) stray = 1'b1;
      end
      chk("rst_mid_no_result", {31'd0, stray}, 32'd0);
      run16(alu_add, 16'd2, 16'd3, rf, rcc, rerr, lat, busy_ok, rel_ok);
      chk("post_rst_add_f",   {16'd0, rf}, 32'd5);
      chk("post_rst_add_lat", lat, 1);
      chk("post_rst_add_err", {31'd0, rerr}, 32'd0);

      // WIDTH=8 multiply overflowing to zero
      @(negedge clk);
      v8_in_valid = 1'b1; v8_aluop = alu_mul; v8_a = 8'h10; v8_b = 8'h10;
      @(posedge clk); #1;
      v8_in_valid = 1'b0;
      lat = 1;
      while (!v8_out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("w8_mul_latency", lat, 9);
      chk("w8_mul_f",   {24'd0, v8_f},   32'h00);
      chk("w8_mul_cc",  {29'd0, v8_cc},  32'h2);
      chk("w8_mul_err", {31'd0, v8_err}, 32'd0);
      @(negedge clk); v8_out_ready = 1'b1;
      @(posedge clk); #1;
      v8_out_ready = 1'b0;
      chk("w8_release", {31'd0, v8_in_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
